// File: rtl/idma_ch_event_collector_pkg.sv
// Shared constants for the iDMA channel event collector: register map,
// field positions in STATUS/CLEAR/MASK and the per-channel pending-bit order.
package idma_ch_event_collector_pkg;

  localparam logic [1:0] IDMA_EVT_ADDR_STATUS = 2'd0;
  localparam logic [1:0] IDMA_EVT_ADDR_CLEAR  = 2'd1;
  localparam logic [1:0] IDMA_EVT_ADDR_MASK   = 2'd2;
  localparam logic [1:0] IDMA_EVT_ADDR_OUTST  = 2'd3;

  localparam int IDMA_EVT_DONE_LSB   = 0;
  localparam int IDMA_EVT_ERR_LSB    = 8;
  localparam int IDMA_EVT_IDLE_LSB   = 16;
  localparam int IDMA_EVT_CNTERR_LSB = 24;

  // Bit order of the 4-bit pending/clear vectors inside each tracker
  localparam int PEND_DONE   = 0;
  localparam int PEND_ERR    = 1;
  localparam int PEND_IDLE   = 2;
  localparam int PEND_CNTERR = 3;

  function automatic logic [31:0] field_mask(int num_ch);
    logic [31:0] m;
    m = '0;
    for (int c = 0; c < num_ch; c++) begin
      m[IDMA_EVT_DONE_LSB + c]   = 1'b1;
      m[IDMA_EVT_ERR_LSB + c]    = 1'b1;
      m[IDMA_EVT_IDLE_LSB + c]   = 1'b1;
      m[IDMA_EVT_CNTERR_LSB + c] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/idma_evt_ch_tracker.sv
// Per-channel state: outstanding-transfer counter, registered busy level,
// sticky pending bits (done/err/idle/cnterr) and the delayed done pulse.
module idma_evt_ch_tracker
  import idma_ch_event_collector_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             start,
  input  logic             done,
  input  logic             error,
  input  logic [3:0]       clear,
  output logic [3:0]       pending,
  output logic [3:0]       pending_next,
  output logic [CNT_W-1:0] cnt,
  output logic             done_evt
);

  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [3:0]       pend_q, pend_set;
  logic             busy_q, done_q, cnt_err;

  // Saturating up/down counter; over/underflow attempts hold the value and flag cnterr
  always_comb begin
    cnt_next = cnt_q;
    cnt_err  = 1'b0;
    if (start && !done) begin
      if (cnt_q == '1) cnt_err = 1'b1;
      else             cnt_next = cnt_q + CNT_W'(1);
    end else if (done && !start) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_next = cnt_q - CNT_W'(1);
    end
    pend_set              = '0;
    pend_set[PEND_DONE]   = done;
    pend_set[PEND_ERR]    = error;
    pend_set[PEND_IDLE]   = busy_q & ~busy;
    pend_set[PEND_CNTERR] = cnt_err;
    pending_next          = (pend_q & ~clear) | pend_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_next;
      pend_q <= pending_next;
      busy_q <= busy;
      done_q <= done;
    end
  end

  assign pending  = pend_q;
  assign cnt      = cnt_q;
  assign done_evt = done_q;

endmodule

// File: rtl/idma_ch_event_collector.sv
// Collects iDMA channel IRQ lines into sticky pending bits with a maskable
// level interrupt and a small word-addressed status/clear/mask/counter port.
module idma_ch_event_collector
  import idma_ch_event_collector_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] ch_busy_i,
  input  logic [NUM_CH-1:0] ch_start_i,
  input  logic [NUM_CH-1:0] ch_done_i,
  input  logic [NUM_CH-1:0] ch_error_i,
  input  logic              cfg_valid_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_addr_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic              cfg_ready_o,
  output logic              cfg_rvalid_o,
  output logic [31:0]       cfg_rdata_o,
  output logic [NUM_CH-1:0] done_evt_o,
  output logic              irq_o
);

  localparam logic [31:0] FIELDS = field_mask(int'(NUM_CH));

  logic [3:0]       pend     [NUM_CH];
  logic [3:0]       pend_nxt [NUM_CH];
  logic [3:0]       clr      [NUM_CH];
  logic [CNT_W-1:0] cnt      [NUM_CH];

  logic [31:0] wdata_f, status, status_next, outst, mask_q, mask_next, rdata_next;
  logic [31:0] rdata_q;
  logic        wr, rd, rvalid_q, irq_q, irq_next;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    idma_evt_ch_tracker #(.CNT_W(CNT_W)) u_trk (
      .clk          (clk_i),
      .rst_n        (rst_ni),
      .busy         (ch_busy_i[c]),
      .start        (ch_start_i[c]),
      .done         (ch_done_i[c]),
      .error        (ch_error_i[c]),
      .clear        (clr[c]),
      .pending      (pend[c]),
      .pending_next (pend_nxt[c]),
      .cnt          (cnt[c]),
      .done_evt     (done_evt_o[c])
    );
  end

  assign wr      = cfg_valid_i & cfg_we_i;
  assign rd      = cfg_valid_i & ~cfg_we_i;
  assign wdata_f = cfg_wdata_i & FIELDS;

  // Scatter per-channel pending bits into the register layout and gather clears back
  always_comb begin
    status      = '0;
    status_next = '0;
    outst       = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      clr[c] = '0;
      if (wr && cfg_addr_i == IDMA_EVT_ADDR_CLEAR) begin
        clr[c][PEND_DONE]   = wdata_f[IDMA_EVT_DONE_LSB + c];
        clr[c][PEND_ERR]    = wdata_f[IDMA_EVT_ERR_LSB + c];
        clr[c][PEND_IDLE]   = wdata_f[IDMA_EVT_IDLE_LSB + c];
        clr[c][PEND_CNTERR] = wdata_f[IDMA_EVT_CNTERR_LSB + c];
      end
      status[IDMA_EVT_DONE_LSB + c]        = pend[c][PEND_DONE];
      status[IDMA_EVT_ERR_LSB + c]         = pend[c][PEND_ERR];
      status[IDMA_EVT_IDLE_LSB + c]        = pend[c][PEND_IDLE];
      status[IDMA_EVT_CNTERR_LSB + c]      = pend[c][PEND_CNTERR];
      status_next[IDMA_EVT_DONE_LSB + c]   = pend_nxt[c][PEND_DONE];
      status_next[IDMA_EVT_ERR_LSB + c]    = pend_nxt[c][PEND_ERR];
      status_next[IDMA_EVT_IDLE_LSB + c]   = pend_nxt[c][PEND_IDLE];
      status_next[IDMA_EVT_CNTERR_LSB + c] = pend_nxt[c][PEND_CNTERR];
      outst[8*c +: CNT_W]                  = cnt[c];
    end
  end

  always_comb begin
    mask_next = mask_q;
    if (wr && cfg_addr_i == IDMA_EVT_ADDR_MASK) mask_next = wdata_f;
    irq_next = |(status_next & mask_next);
    rdata_next = '0;
    if (rd) begin
      case (cfg_addr_i)
        IDMA_EVT_ADDR_STATUS: rdata_next = status;
        IDMA_EVT_ADDR_MASK:   rdata_next = mask_q;
        IDMA_EVT_ADDR_OUTST:  rdata_next = outst;
        default:              rdata_next = '0;
      endcase
    end
  end

  // irq is computed from next-state pending/mask so it tracks them with no extra lag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mask_q   <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mask_q   <= mask_next;
      irq_q    <= irq_next;
      rvalid_q <= rd;
      rdata_q  <= rdata_next;
    end
  end

  assign cfg_ready_o  = 1'b1;
  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_idma_ch_event_collector.sv
// Directed bench for idma_ch_event_collector (NUM_CH=2, CNT_W=4) with
// hand-computed expected register, irq and done_evt values.
module tb_idma_ch_event_collector;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  ch_busy_i, ch_start_i, ch_done_i, ch_error_i;
  logic        cfg_valid_i, cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic        cfg_ready_o, cfg_rvalid_o, irq_o;
  logic [31:0] cfg_rdata_o;
  logic [1:0]  done_evt_o;

  int compared   = 0;
  int mismatched = 0;

  idma_ch_event_collector #(.NUM_CH(2), .CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .ch_busy_i    (ch_busy_i),
    .ch_start_i   (ch_start_i),
    .ch_done_i    (ch_done_i),
    .ch_error_i   (ch_error_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .done_evt_o   (done_evt_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    ch_start_i  = '0;
    ch_done_i   = '0;
    ch_error_i  = '0;
    cfg_valid_i = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_wdata_i = '0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    cfg_valid_i = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    tick();
    idle_inputs();
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    cfg_valid_i = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = addr;
    tick();
    idle_inputs();
    checkOutput({tag, "_rvalid"}, 32'(cfg_rvalid_o), 32'd1);
    checkOutput(tag, cfg_rdata_o, exp);
  endtask

  task automatic pulse(input logic [1:0] start, input logic [1:0] done, input logic [1:0] err);
    ch_start_i = start;
    ch_done_i  = done;
    ch_error_i = err;
    tick();
    idle_inputs();
  endtask

  initial begin
    // Reset with every input toggling
    idle_inputs();
    ch_busy_i = '0;
    rst_ni    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ch_busy_i   = 2'b11;
      ch_start_i  = 2'b11;
      ch_done_i   = 2'b11;
      ch_error_i  = 2'b11;
      cfg_valid_i = 1'b1;
      cfg_we_i    = i[0];
      cfg_addr_i  = 2'd2;
      cfg_wdata_i = 32'hFFFF_FFFF;
      tick();
      checkOutput("rst_irq", 32'(irq_o), 32'd0);
      checkOutput("rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
      checkOutput("rst_rdata", cfg_rdata_o, 32'd0);
      checkOutput("rst_done_evt", 32'(done_evt_o), 32'd0);
      checkOutput("rst_ready", 32'(cfg_ready_o), 32'd1);
    end
    idle_inputs();
    ch_busy_i = '0;
    rst_ni    = 1'b1;
    tick();
    read_check("rst_status", 2'd0, 32'h0);
    read_check("rst_outst", 2'd3, 32'h0);
    read_check("rst_mask", 2'd2, 32'h0);
    checkOutput("rdata_back_to_0", cfg_rdata_o, 32'd0);
    tick();
    checkOutput("rvalid_drop", 32'(cfg_rvalid_o), 32'd0);

    // Counting on ch0
    for (int i = 0; i < 3; i++) pulse(2'b01, 2'b00, 2'b00);
    pulse(2'b00, 2'b01, 2'b00);
    read_check("cnt_3s1d", 2'd3, 32'h0000_0002);
    pulse(2'b01, 2'b01, 2'b00);
    read_check("cnt_same_cycle", 2'd3, 32'h0000_0002);

    // Saturation on ch1, underflow on ch0
    for (int i = 0; i < 16; i++) pulse(2'b10, 2'b00, 2'b00);
    read_check("cnt_sat", 2'd3, 32'h0000_0F02);
    read_check("status_cnterr1", 2'd0, 32'h0200_0001);
    pulse(2'b00, 2'b01, 2'b00);
    pulse(2'b00, 2'b01, 2'b00);
    read_check("status_no_uflow", 2'd0, 32'h0200_0001);
    pulse(2'b00, 2'b01, 2'b00);
    read_check("status_uflow", 2'd0, 32'h0300_0001);
    read_check("cnt_after_uflow", 2'd3, 32'h0000_0F00);
    cfg_write(2'd1, 32'hFFFF_FFFF);
    read_check("status_cleared", 2'd0, 32'h0);

    // IRQ path
    cfg_write(2'd2, 32'h1);
    checkOutput("irq_mask_nopend", 32'(irq_o), 32'd0);
    ch_done_i = 2'b01;
    tick();
    idle_inputs();
    checkOutput("irq_done", 32'(irq_o), 32'd1);
    checkOutput("done_evt", 32'(done_evt_o), 32'd1);
    tick();
    checkOutput("done_evt_pulse", 32'(done_evt_o), 32'd0);
    checkOutput("irq_level", 32'(irq_o), 32'd1);
    cfg_write(2'd1, 32'h1);
    checkOutput("irq_cleared", 32'(irq_o), 32'd0);
    cfg_valid_i = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = 2'd1;
    cfg_wdata_i = 32'h1;
    ch_done_i   = 2'b01;
    tick();
    idle_inputs();
    checkOutput("irq_set_wins", 32'(irq_o), 32'd1);
    read_check("status_set_wins", 2'd0, 32'h0100_0001);
    cfg_write(2'd1, 32'hFFFF_FFFF);
    cfg_write(2'd2, 32'h0);
    checkOutput("irq_masked_off", 32'(irq_o), 32'd0);

    // Idle and error events
    ch_busy_i = 2'b10;
    tick();
    ch_busy_i = 2'b00;
    tick();
    read_check("status_idle1", 2'd0, 32'h0002_0000);
    pulse(2'b00, 2'b00, 2'b01);
    read_check("status_err0", 2'd0, 32'h0002_0100);
    checkOutput("irq_err_masked", 32'(irq_o), 32'd0);
    cfg_write(2'd2, 32'h100);
    checkOutput("irq_after_mask", 32'(irq_o), 32'd1);
    read_check("mask_rb", 2'd2, 32'h100);

    // Register port corner cases
    read_check("clear_reads0", 2'd1, 32'h0);
    cfg_write(2'd0, 32'h0000_FFFF);
    read_check("status_ro", 2'd0, 32'h0002_0100);
    cfg_write(2'd2, 32'hFFFF_FFFF);
    read_check("mask_fields", 2'd2, 32'h0303_0303);
    ch_error_i = 2'b10;
    read_check("read_pre_event", 2'd0, 32'h0002_0100);
    read_check("read_post_event", 2'd0, 32'h0002_0300);

    // Mid-operation reset
    rst_ni     = 1'b0;
    ch_start_i = 2'b11;
    ch_done_i  = 2'b01;
    tick();
    idle_inputs();
    rst_ni = 1'b1;
    checkOutput("midrst_irq", 32'(irq_o), 32'd0);
    checkOutput("midrst_done_evt", 32'(done_evt_o), 32'd0);
    read_check("midrst_status", 2'd0, 32'h0);
    read_check("midrst_outst", 2'd3, 32'h0);
    read_check("midrst_mask", 2'd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
